// File: rtl/apb_arb_pkg.sv
// Shared definitions for the two-requester APB front end.
//   APB_ADDR_W / APB_DATA_W : bridge address and data widths
//   arb_state_t             : one-hot arbiter state encoding
package apb_arb_pkg;

  localparam int APB_ADDR_W = 9;
  localparam int APB_DATA_W = 8;

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    ISSUE = 4'b0010,
    WAIT  = 4'b0100,
    RESP  = 4'b1000
  } arb_state_t;

endpackage

// File: rtl/apb_rr_pick2.sv
// Two-way round-robin winner select (purely combinational).
//   valid[1:0]  : pending command per requester
//   last_owner  : requester granted most recently
//   grant_vld   : at least one requester is pending
//   winner      : index of the requester to serve
module apb_rr_pick2 (
  input  logic [1:0] valid,
  input  logic       last_owner,
  output logic       grant_vld,
  output logic       winner
);

  assign grant_vld = |valid;
  // On a tie the requester that did not go last wins; otherwise the lone one.
  assign winner    = (&valid) ? ~last_owner : valid[1];

endmodule

// File: rtl/apb_req_arbiter.sv
// Two-requester front end for the APB master bridge. Grants one command at a
// time with round-robin priority, drives the bridge command inputs, follows
// the APB handshake to completion and returns data/error to the owner. A
// watchdog forces an error completion if the slave hangs.
//   PCLK, PRESETn              : clock, asynchronous active-low reset
//   reqN_valid/write/addr/wdata: command from requester N
//   reqN_ready                 : command accepted this cycle (combinational)
//   reqN_done/rdata/err        : one-cycle completion with read data / error
//   transfer, READ_WRITE, apb_*: command drive to the bridge
//   bus_penable/pready/pslverr/prdata : handshake observed from the bus
//   busy, owner                : arbiter not idle, current/last granted index
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  req0_valid,
  input  logic                  req0_write,
  input  logic [APB_ADDR_W-1:0] req0_addr,
  input  logic [APB_DATA_W-1:0] req0_wdata,
  output logic                  req0_ready,
  output logic                  req0_done,
  output logic [APB_DATA_W-1:0] req0_rdata,
  output logic                  req0_err,
  input  logic                  req1_valid,
  input  logic                  req1_write,
  input  logic [APB_ADDR_W-1:0] req1_addr,
  input  logic [APB_DATA_W-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic                  req1_done,
  output logic [APB_DATA_W-1:0] req1_rdata,
  output logic                  req1_err,
  output logic                  transfer,
  output logic                  READ_WRITE,
  output logic [APB_ADDR_W-1:0] apb_write_paddr,
  output logic [APB_ADDR_W-1:0] apb_read_paddr,
  output logic [APB_DATA_W-1:0] apb_write_data,
  input  logic                  bus_penable,
  input  logic                  bus_pready,
  input  logic                  bus_pslverr,
  input  logic [APB_DATA_W-1:0] bus_prdata,
  output logic                  busy,
  output logic                  owner
);

  arb_state_t                 state;
  logic                       last_owner;
  logic [CNT_W-1:0]           wdog_cnt;
  logic [CNT_W-1:0]           wdog_nxt;
  logic [1:0]                 done_q;
  logic [1:0]                 err_q;
  logic [1:0][APB_DATA_W-1:0] rdata_q;

  logic                       grant_vld;
  logic                       winner;
  logic                       grant;
  logic                       in_flight;
  logic                       timeout;
  logic                       fin;
  logic                       fin_err;
  logic [APB_DATA_W-1:0]      fin_rdata;
  logic                       sel_write;
  logic [APB_ADDR_W-1:0]      sel_addr;
  logic [APB_DATA_W-1:0]      sel_wdata;

  apb_rr_pick2 u_pick (
    .valid      ({req1_valid, req0_valid}),
    .last_owner (last_owner),
    .grant_vld  (grant_vld),
    .winner     (winner)
  );

  // Holding off while PENABLE is still high keeps a grant from overlapping
  // the tail of a transfer the bridge has not yet closed.
  assign grant      = (state == IDLE) && grant_vld && !bus_penable;
  assign req0_ready = grant && !winner;
  assign req1_ready = grant &&  winner;

  // Dropped in the PENABLE cycle so the bridge does not chain a second transfer.
  assign transfer   = (state == ISSUE) && !bus_penable;
  assign busy       = (state != IDLE);

  assign in_flight  = (state == ISSUE) || (state == WAIT);
  assign wdog_nxt   = wdog_cnt + CNT_W'(1);
  assign timeout    = in_flight && (wdog_nxt == CNT_W'(TIMEOUT_CYCLES - 1));

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    sel_write = req0_write;
    sel_addr  = req0_addr;
    sel_wdata = req0_wdata;
    if (winner) begin
      sel_write = req1_write;
      sel_addr  = req1_addr;
      sel_wdata = req1_wdata;
    end
  end

  // Completion priority: watchdog, then slave error, then normal PREADY.
  always_comb begin
    fin       = 1'b0;
    fin_err   = 1'b0;
    fin_rdata = '0;
    if (in_flight) begin
      if (timeout || bus_pslverr) begin
        fin     = 1'b1;
        fin_err = 1'b1;
      end else if ((state == WAIT) && bus_penable && bus_pready) begin
        fin       = 1'b1;
        fin_rdata = bus_prdata;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state           <= IDLE;
      last_owner      <= 1'b1;
      owner           <= 1'b0;
      wdog_cnt        <= '0;
      READ_WRITE      <= 1'b0;
      apb_write_paddr <= '0;
      apb_read_paddr  <= '0;
      apb_write_data  <= '0;
      done_q          <= '0;
      err_q           <= '0;
      rdata_q         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            state           <= ISSUE;
            owner           <= winner;
            last_owner      <= winner;
            wdog_cnt        <= '0;
            READ_WRITE      <= ~sel_write;
            apb_write_paddr <= sel_addr;
            apb_read_paddr  <= sel_addr;
            apb_write_data  <= sel_wdata;
          end
        end
        ISSUE, WAIT: begin
          wdog_cnt <= wdog_nxt;
          if (fin) begin
            state          <= RESP;
            done_q[owner]  <= 1'b1;
            err_q[owner]   <= fin_err;
            rdata_q[owner] <= fin_rdata;
          end else if ((state == ISSUE) && bus_penable) begin
            state <= WAIT;
          end
        end
        RESP: begin
          state   <= IDLE;
          done_q  <= '0;
          err_q   <= '0;
          rdata_q <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req0_done  = done_q[0];
  assign req1_done  = done_q[1];
  assign req0_err   = err_q[0];
  assign req1_err   = err_q[1];
  assign req0_rdata = rdata_q[0];
  assign req1_rdata = rdata_q[1];

endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
- Two-requester front end for the APB master bridge, for example a CPU port and a DMA port.
- Accepts one command at a time from either requester with round-robin priority.
- Drives the bridge's transfer, READ_WRITE, address and write-data inputs, and tracks the APB handshake to completion.
- Returns read data and error status to the owning requester; a watchdog guards against a hung slave.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles from grant to completion before forced error termination; legal range 4 to 255.
- CNT_W, 8: width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- PCLK  in  1  bus clock; all logic is on its rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has a command pending.
- req0_write  in  1  1 = write, 0 = read.
- req0_addr  in  9  target address; bit 8 selects slave 2, 0 selects slave 1.
- req0_wdata  in  8  write data.
- req0_ready  out  1  command accepted this cycle.
- req0_done  out  1  one-cycle completion pulse.
- req0_rdata  out  8  read data; valid while req0_done is high.
- req0_err  out  1  error flag; valid while req0_done is high.
- req1_valid, req1_write, req1_addr, req1_wdata, req1_ready, req1_done, req1_rdata, req1_err: same as requester 0.
- transfer  out  1  to the bridge: start a transfer.
- READ_WRITE  out  1  to the bridge: 1 = read, 0 = write.
- apb_write_paddr  out  9  to the bridge: write address.
- apb_read_paddr  out  9  to the bridge: read address.
- apb_write_data  out  8  to the bridge: write data.
- bus_penable  in  1  bridge PENABLE.
- bus_pready  in  1  slave PREADY.
- bus_pslverr  in  1  bridge PSLVRR.
- bus_prdata  in  8  slave PRDATA.
- busy  out  1  arbiter is not in IDLE.
- owner  out  1  index of the current or last granted requester.

Behaviour:
- Reset values:
  - State is IDLE; last_owner = 1, so requester 0 wins the first tie.
  - All outputs are 0, including transfer, READ_WRITE, both addresses, write data, every req*_ready/done/rdata/err, busy and owner.
  - The watchdog counter is 0.
- FSM states: IDLE, ISSUE, WAIT, RESP; one-hot encoded.
- IDLE:
  - A grant is possible when at least one reqN_valid is high and bus_penable is low.
  - If only one requester is valid, it wins. If both are valid, the winner is the requester other than last_owner.
  - reqN_ready is combinational and high for the winner in this cycle only.
  - On the clock edge the command (write, addr, wdata) is latched. owner and last_owner are set to the winner, the watchdog is cleared, and the state moves to ISSUE.
  - Requesters must hold valid and payload stable until ready is seen.
- Bridge drive:
  - READ_WRITE = ~latched write.
  - apb_write_paddr and apb_read_paddr both carry the latched address.
  - apb_write_data carries the latched data.
  - These drives are registered and held stable from ISSUE through RESP.
- ISSUE:
  - transfer = 1 while bus_penable is 0; it is forced low combinationally in the cycle bus_penable is seen high. This prevents the bridge from starting a back-to-back transfer.
  - Moves to WAIT on bus_penable = 1.
- WAIT:
  - transfer = 0.
  - Moves to RESP on bus_penable & bus_pready; rdata captures bus_prdata and err = 0.
  - Moves to RESP on bus_pslverr = 1 in ISSUE or WAIT; err = 1 and rdata = 0.
  - If pready and pslverr occur in the same cycle, pslverr takes priority: err = 1.
- Watchdog:
  - The counter increments every cycle spent in ISSUE or WAIT.
  - When it reaches TIMEOUT_CYCLES - 1 without completion, the state moves to RESP with err = 1 and rdata = 0.
  - Timeout takes priority over a completion arriving in that same cycle.
- RESP:
  - Lasts exactly one cycle; reqN_done = 1 for the owner only, with rdata and err registered.
  - Then returns to IDLE.
  - A grant can occur no earlier than the cycle after RESP, so turnaround between transfers is at least one idle cycle.
- Non-owner requester: ready and done stay 0 throughout; its valid may be asserted at any time and it is served next.
- Latency: with a zero-wait slave, ready to done is 4 cycles; each slave wait state adds one cycle.
- Reset mid-operation: asynchronous return to the reset values. No done pulse is issued for the aborted command, and the requester must re-issue it.
- busy = (state != IDLE).

Decomposition:
- Shared package apb_arb_pkg holds:
  - the state encoding constants: IDLE = 4'b0001, ISSUE = 4'b0010, WAIT = 4'b0100, RESP = 4'b1000;
  - APB_ADDR_W = 9 and APB_DATA_W = 8.
- Optional sub-module apb_rr_pick2: a combinational two-way round-robin winner select with inputs valid[1:0] and last_owner, and outputs grant_vld and winner.
- The FSM, command latch and watchdog stay in the top module.

Test Plan:
- Write from requester 0 only: addr 0x005, wdata 0xA5, zero-wait slave.
  - transfer is high for the cycles before PENABLE; READ_WRITE = 0; apb_write_paddr = 0x005.
  - req0_done pulses 4 cycles after req0_ready, with err = 0.
- Read from requester 1: addr 0x1F0, slave returns 0x3C after 2 wait states.
  - READ_WRITE = 1; req1_rdata = 0x3C when req1_done is high; done arrives 6 cycles after ready.
- Both requesters valid continuously with 3 commands each.
  - Grant order is 0,1,0,1,0,1; owner toggles accordingly; no back-to-back transfer is started while transfer is high.
- Slave never asserts PREADY, with TIMEOUT_CYCLES = 16.
  - req0_done and req0_err pulse together 16 cycles after grant, with rdata = 0x00.
- bus_pslverr is asserted in WAIT together with PREADY.
  - err = 1 and rdata = 0x00; the next queued requester is granted after one idle cycle.
- PRESETn is pulled low while in WAIT.
  - All outputs drop to 0 immediately; no done pulse follows; after release the first tie is won by requester 0.
